// File: rtl/io_read_fill_controller.sv
// io_read_fill_controller
// Keeps a one-word buffer and a full flag (EF) for each I/O read port.
// Ports that are enabled and empty are refilled from one upstream source.
// A round-robin pointer picks the next port to fill. The two-state FSM
// (IDLE/REQ) is visible on busy, which is high exactly when the FSM is in REQ.
//
// Upstream handshake (src_req / src_ack):
//   src_req is a registered request, high for the whole REQ state.
//   src_port is stable from the cycle src_req rises until the ack edge.
//   The source accepts the request and supplies its word in one step:
//   it drives src_ack=1 with src_data valid.
//   The word is captured on the first rising edge where src_req and
//   src_ack are both high. At that same edge src_req drops.
//   src_ack is ignored whenever src_req is low.
module io_read_fill_controller #(
  parameter int WORD_WIDTH      = 36,
  parameter int READ_PORT_COUNT = 4,
  parameter int PORT_SEL_WIDTH  = 2
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic [READ_PORT_COUNT-1:0]            port_enable,
  input  logic [READ_PORT_COUNT-1:0]            read_rden,
  output logic [READ_PORT_COUNT-1:0]            read_EF,
  output logic [READ_PORT_COUNT*WORD_WIDTH-1:0] read_data_IO,
  output logic                                  src_req,
  output logic [PORT_SEL_WIDTH-1:0]             src_port,
  input  logic                                  src_ack,
  input  logic [WORD_WIDTH-1:0]                 src_data,
  output logic                                  busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  localparam logic [PORT_SEL_WIDTH:0]   PORT_COUNT_W = (PORT_SEL_WIDTH+1)'(READ_PORT_COUNT);
  localparam logic [PORT_SEL_WIDTH-1:0] LAST_PORT    = PORT_SEL_WIDTH'(READ_PORT_COUNT - 1);

  state_e                      state_q, state_d;
  logic [PORT_SEL_WIDTH-1:0]   src_port_q, src_port_d;
  logic [PORT_SEL_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [READ_PORT_COUNT-1:0]  ef_q, ef_d;
  logic [WORD_WIDTH-1:0]       buf_q [READ_PORT_COUNT];
  logic [WORD_WIDTH-1:0]       buf_d [READ_PORT_COUNT];

  logic [READ_PORT_COUNT-1:0]  cand;
  logic                        pick_valid;
  logic [PORT_SEL_WIDTH-1:0]   pick_idx;

  // Round-robin pick: the first enabled empty port at or after rr_ptr, with wrap.
  // The search uses the registered EF bits, so a port emptied at an edge
  // cannot be picked in that same cycle.
  always_comb begin
    cand       = port_enable & ~ef_q;
    pick_valid = 1'b0;
    pick_idx   = '0;
    // Walk from the farthest offset down to offset 0. The last hit found is
    // then the nearest one to rr_ptr.
    for (int off = READ_PORT_COUNT - 1; off >= 0; off--) begin
      logic [PORT_SEL_WIDTH:0]   sum;
      logic [PORT_SEL_WIDTH-1:0] idx;
      sum = {1'b0, rr_ptr_q} + (PORT_SEL_WIDTH+1)'(off);
      if (sum >= PORT_COUNT_W) begin
        sum = sum - PORT_COUNT_W;
      end
      idx = sum[PORT_SEL_WIDTH-1:0];
      if (cand[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  // Next state: FSM transitions, consume clears, and the fill on ack.
  always_comb begin
    state_d    = state_q;
    src_port_d = src_port_q;
    rr_ptr_d   = rr_ptr_q;
    // A consume strobe on an empty port leaves its EF bit at 0. Every
    // strobe bit acts on its own port independently.
    ef_d       = ef_q & ~read_rden;
    buf_d      = buf_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d    = ST_REQ;
          src_port_d = pick_idx;
        end
      end
      ST_REQ: begin
        // Dropping port_enable does not abort the request; only an ack ends it.
        if (src_ack) begin
          buf_d[src_port_q] = src_data;
          ef_d[src_port_q]  = 1'b1;
          rr_ptr_d          = (src_port_q == LAST_PORT) ? '0 : src_port_q + 1'b1;
          state_d           = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, port index, pointer, flags and buffers; all clear asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      src_port_q <= '0;
      rr_ptr_q   <= '0;
      ef_q       <= '0;
      for (int i = 0; i < READ_PORT_COUNT; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      src_port_q <= src_port_d;
      rr_ptr_q   <= rr_ptr_d;
      ef_q       <= ef_d;
      for (int i = 0; i < READ_PORT_COUNT; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  // Outputs come straight from registers. Reset drops src_req at once.
  always_comb begin
    src_req  = (state_q == ST_REQ);
    busy     = (state_q == ST_REQ);
    src_port = src_port_q;
    read_EF  = ef_q;
  end

  // Pack the buffers onto the flat data bus, with port 0 in the LSBs.
  for (genvar g = 0; g < READ_PORT_COUNT; g++) begin : g_data
    assign read_data_IO[g*WORD_WIDTH +: WORD_WIDTH] = buf_q[g];
  end

endmodule

// File: tb/tb_io_read_fill_controller.sv
// Self-checking bench for io_read_fill_controller.
// Each fill that is driven pushes {port, data} onto a queue. The entry is
// popped and compared against the DUT buffer once the fill edge has passed.
module tb_io_read_fill_controller;

  localparam int W  = 36;
  localparam int N  = 4;
  localparam int PW = 2;

  logic             clock;
  logic             reset_n;
  logic [N-1:0]     port_enable;
  logic [N-1:0]     read_rden;
  logic [N-1:0]     read_EF;
  logic [N*W-1:0]   read_data_IO;
  logic             src_req;
  logic [PW-1:0]    src_port;
  logic             src_ack;
  logic [W-1:0]     src_data;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [PW+W-1:0] exp_q[$];
  logic [W-1:0]    model_buf [N];

  io_read_fill_controller #(
    .WORD_WIDTH(W), .READ_PORT_COUNT(N), .PORT_SEL_WIDTH(PW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .port_enable(port_enable),
    .read_rden(read_rden), .read_EF(read_EF), .read_data_IO(read_data_IO),
    .src_req(src_req), .src_port(src_port), .src_ack(src_ack),
    .src_data(src_data), .busy(busy)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic apply_reset();
    reset_n     = 1'b0;
    port_enable = '0;
    read_rden   = '0;
    src_ack     = 1'b0;
    src_data    = '0;
    exp_q.delete();
    for (int i = 0; i < N; i++) model_buf[i] = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // driver tasks
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (src_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drive_ack(input int hold, input logic [W-1:0] data);
    repeat (hold) @(negedge clock);
    src_data = data;
    src_ack  = 1'b1;
    exp_q.push_back({src_port, data});
    @(negedge clock);
    src_ack = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_word();
    return W'({$urandom(), $urandom()});
  endfunction

  // tests
  task automatic test_reset();
    reset_n = 1'b0; port_enable = '0; read_rden = '0; src_ack = 1'b0; src_data = '0;
    for (int i = 0; i < N; i++) model_buf[i] = '0;
    @(negedge clock);
    n_checks++;
    if (src_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_req_busy: got req=%b busy=%b required 0 0", src_req, busy);
    end
    n_checks++;
    if (read_EF !== '0 || src_port !== '0) begin
      n_fail++; $display("FAIL reset_ef_port: got ef=%b port=%0d required 0 0", read_EF, src_port);
    end
    n_checks++;
    if (read_data_IO !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h required 0", read_data_IO);
    end
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if (src_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: got req=%b required 0", src_req);
    end
  endtask

  task automatic test_basic_fill();
    bit ok;
    logic [PW+W-1:0] e;
    port_enable = 4'b0001;
    wait_req(ok);
    n_checks++;
    if (!ok || src_port !== 2'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_req: got ok=%0d port=%0d busy=%b required 1 0 1", ok, src_port, busy);
    end
    drive_ack(1, 36'h123456789);
    n_checks++;
    if (busy !== 1'b0 || src_req !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy: got busy=%b req=%b required 0 0", busy, src_req);
    end
    n_checks++;
    if (read_EF !== 4'b0001) begin
      n_fail++; $display("FAIL basic_ef: got %b required 0001", read_EF);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (read_data_IO[0 +: W] !== e[W-1:0] || read_data_IO[0 +: W] !== 36'h123456789) begin
      n_fail++; $display("FAIL basic_buf0: got %h required %h", read_data_IO[0 +: W], e[W-1:0]);
    end
    model_buf[0] = e[W-1:0];
    port_enable = '0;
  endtask

  task automatic test_round_robin();
    int g_port[4];
    int g_cyc[4];
    int n_g;
    logic [PW+W-1:0] e;
    int p;
    apply_reset();
    n_g = 0;
    port_enable = 4'b1111;
    src_ack     = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clock);
      src_data = rand_word();
      if (src_req) begin
        if (n_g < 4) begin
          g_port[n_g] = int'(src_port);
          g_cyc[n_g]  = cyc;
        end
        n_g++;
        exp_q.push_back({src_port, src_data});
      end
    end
    src_ack = 1'b0;
    n_checks++;
    if (n_g != 4) begin
      n_fail++; $display("FAIL rr_count: got %0d grants required 4", n_g);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (g_port[k] != k) begin
          n_fail++; $display("FAIL rr_order: grant %0d got port %0d required %0d", k, g_port[k], k);
        end
        if (k > 0) begin
          n_checks++;
          if (g_cyc[k] - g_cyc[k-1] != 2) begin
            n_fail++; $display("FAIL rr_spacing: grant %0d got %0d cycles required 2", k, g_cyc[k] - g_cyc[k-1]);
          end
        end
      end
    end
    n_checks++;
    if (read_EF !== 4'b1111 || src_req !== 1'b0) begin
      n_fail++; $display("FAIL rr_final: got ef=%b req=%b required 1111 0", read_EF, src_req);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      p = int'(e[W +: PW]);
      n_checks++;
      if (read_data_IO[p*W +: W] !== e[W-1:0]) begin
        n_fail++; $display("FAIL rr_buf: port %0d got %h required %h", p, read_data_IO[p*W +: W], e[W-1:0]);
      end
      model_buf[p] = e[W-1:0];
    end
    port_enable = '0;
  endtask

  task automatic test_wrap();
    bit ok;
    logic [PW+W-1:0] e;
    int p;
    // Consume port 2; its buffer must be retained.
    read_rden = 4'b0100;
    @(negedge clock);
    read_rden = '0;
    n_checks++;
    if (read_EF !== 4'b1011 || read_data_IO[2*W +: W] !== model_buf[2]) begin
      n_fail++; $display("FAIL consume_keep: got ef=%b buf2=%h required 1011 %h", read_EF, read_data_IO[2*W +: W], model_buf[2]);
    end
    // Refill port 2 so the pointer moves to 3.
    port_enable = 4'b0100;
    wait_req(ok);
    drive_ack(0, rand_word());
    port_enable = '0;
    // Empty ports 3 and 1 in one cycle.
    read_rden = 4'b1010;
    @(negedge clock);
    read_rden = '0;
    n_checks++;
    if (read_EF !== 4'b0101) begin
      n_fail++; $display("FAIL multi_rden: got %b required 0101", read_EF);
    end
    port_enable = 4'b1111;
    wait_req(ok);
    n_checks++;
    if (!ok || src_port !== 2'd3) begin
      n_fail++; $display("FAIL wrap_first: got ok=%0d port=%0d required 1 3", ok, src_port);
    end
    drive_ack(0, rand_word());
    wait_req(ok);
    n_checks++;
    if (!ok || src_port !== 2'd1) begin
      n_fail++; $display("FAIL wrap_second: got ok=%0d port=%0d required 1 1", ok, src_port);
    end
    drive_ack(0, rand_word());
    port_enable = '0;
    // The pointer should now be 2: empty ports 1 and 2; port 2 must win.
    read_rden = 4'b0110;
    @(negedge clock);
    read_rden = '0;
    port_enable = 4'b1111;
    wait_req(ok);
    n_checks++;
    if (!ok || src_port !== 2'd2) begin
      n_fail++; $display("FAIL wrap_ptr: got ok=%0d port=%0d required 1 2", ok, src_port);
    end
    drive_ack(0, rand_word());
    wait_req(ok);
    n_checks++;
    if (!ok || src_port !== 2'd1) begin
      n_fail++; $display("FAIL wrap_after: got ok=%0d port=%0d required 1 1", ok, src_port);
    end
    drive_ack(0, rand_word());
    port_enable = '0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      p = int'(e[W +: PW]);
      model_buf[p] = e[W-1:0];
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (read_data_IO[i*W +: W] !== model_buf[i]) begin
        n_fail++; $display("FAIL wrap_buf: port %0d got %h required %h", i, read_data_IO[i*W +: W], model_buf[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    logic [PW+W-1:0] e;
    int p;
    read_rden = 4'b0001;
    @(negedge clock);
    read_rden = '0;
    port_enable = 4'b0101;
    wait_req(ok);
    n_checks++;
    if (!ok || src_port !== 2'd0) begin
      n_fail++; $display("FAIL simul_req: got ok=%0d port=%0d required 1 0", ok, src_port);
    end
    src_data  = rand_word();
    src_ack   = 1'b1;
    read_rden = 4'b0100;
    exp_q.push_back({src_port, src_data});
    @(negedge clock);
    src_ack   = 1'b0;
    read_rden = '0;
    n_checks++;
    if (read_EF !== 4'b1011 || src_req !== 1'b0) begin
      n_fail++; $display("FAIL simul_ef: got ef=%b req=%b required 1011 0", read_EF, src_req);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (read_data_IO[0 +: W] !== e[W-1:0]) begin
      n_fail++; $display("FAIL simul_buf0: got %h required %h", read_data_IO[0 +: W], e[W-1:0]);
    end
    model_buf[0] = e[W-1:0];
    @(negedge clock);
    n_checks++;
    if (src_req !== 1'b1 || src_port !== 2'd2) begin
      n_fail++; $display("FAIL simul_rereq: got req=%b port=%0d required 1 2", src_req, src_port);
    end
    drive_ack(0, rand_word());
    e = exp_q.pop_front();
    p = int'(e[W +: PW]);
    n_checks++;
    if (p != 2 || read_data_IO[2*W +: W] !== e[W-1:0] || read_EF !== 4'b1111) begin
      n_fail++; $display("FAIL simul_fill2: got port=%0d buf=%h ef=%b required 2 %h 1111", p, read_data_IO[2*W +: W], e[W-1:0], read_EF);
    end
    model_buf[2] = e[W-1:0];
    port_enable = '0;
  endtask

  task automatic test_invalid_abort();
    bit ok;
    logic [PW+W-1:0] e;
    read_rden = 4'b1000;
    @(negedge clock);
    read_rden = 4'b1000;
    @(negedge clock);
    read_rden = '0;
    n_checks++;
    if (read_EF !== 4'b0111 || src_req !== 1'b0 || read_data_IO[3*W +: W] !== model_buf[3]) begin
      n_fail++; $display("FAIL invalid_rden: got ef=%b req=%b buf3=%h required 0111 0 %h", read_EF, src_req, read_data_IO[3*W +: W], model_buf[3]);
    end
    port_enable = 4'b1000;
    wait_req(ok);
    port_enable = '0;
    @(negedge clock);
    n_checks++;
    if (!ok || src_req !== 1'b1 || src_port !== 2'd3) begin
      n_fail++; $display("FAIL abort_hold: got ok=%0d req=%b port=%0d required 1 1 3", ok, src_req, src_port);
    end
    drive_ack(0, rand_word());
    e = exp_q.pop_front();
    n_checks++;
    if (read_EF !== 4'b1111 || read_data_IO[3*W +: W] !== e[W-1:0]) begin
      n_fail++; $display("FAIL abort_fill: got ef=%b buf3=%h required 1111 %h", read_EF, read_data_IO[3*W +: W], e[W-1:0]);
    end
    model_buf[3] = e[W-1:0];
  endtask

  task automatic test_reset_mid_req();
    bit ok;
    read_rden = 4'b0001;
    @(negedge clock);
    read_rden = '0;
    port_enable = 4'b0001;
    wait_req(ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL rst_setup: got no request required request");
    end
    reset_n  = 1'b0;
    src_ack  = 1'b1;
    src_data = rand_word();
    port_enable = '0;
    #1;
    n_checks++;
    if (src_req !== 1'b0 || read_EF !== '0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: got req=%b ef=%b busy=%b required 0 0 0", src_req, read_EF, busy);
    end
    @(negedge clock);
    n_checks++;
    if (read_data_IO !== '0) begin
      n_fail++; $display("FAIL rst_ack_during: got %h required 0", read_data_IO);
    end
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if (read_data_IO !== '0 || read_EF !== '0 || src_req !== 1'b0) begin
      n_fail++; $display("FAIL rst_ack_after: got data=%h ef=%b req=%b required 0 0 0", read_data_IO, read_EF, src_req);
    end
    src_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_round_robin();
    test_wrap();
    test_simultaneous();
    test_invalid_abort();
    test_reset_mid_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
